// File: rtl/uartcon_rx.sv
// uartcon_rx: 8N1 UART receive engine driven by a 16x-baud oversample clock.
// Deframes LSB-first characters into a one-entry ready/valid output register
// and flags framing errors and overruns as single-cycle pulses.
module uartcon_rx #(
  parameter int unsigned OS_MID = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       os_clk,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int unsigned TCNT_W = 4;
  localparam int unsigned BCNT_W = 3;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_WAIT_HI = 3'd4
  } state_t;

  localparam logic [TCNT_W-1:0] TCNT_MID  = TCNT_W'(OS_MID);
  localparam logic [TCNT_W-1:0] TCNT_LAST = '1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = '1;

  // Registered state
  state_t              state_q, state_d;
  logic                os_d_q, os_d_d;
  logic                rx_meta_q, rx_meta_d;
  logic                rxs_q, rxs_d;
  logic                rxs_d_q, rxs_d_d;
  logic [1:0]          fill_q, fill_d;
  logic                armed_q, armed_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_err_q, overrun_err_d;
  logic                busy_q, busy_d;

  // Combinational helpers
  logic tick_c;
  logic start_edge_c;
  logic deliver_c;

  assign tick_c       = os_clk & ~os_d_q;
  // Edge detect is gated by armed_q so the synchroniser's reset value of 1
  // cannot fake a falling edge when the line is low coming out of reset.
  assign start_edge_c = armed_q & rxs_d_q & ~rxs_q;

  // Next-state, counters, shift register and output register updates
  always_comb begin
    state_d       = state_q;
    os_d_d        = os_clk;
    rx_meta_d     = rxd;
    rxs_d         = rx_meta_q;
    rxs_d_d       = rxs_q;
    fill_d        = {fill_q[0], 1'b1};
    armed_d       = armed_q | (fill_q[1] & rxs_q);
    tcnt_d        = tcnt_q;
    bcnt_d        = bcnt_q;
    sh_d          = sh_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q & ~rx_ready;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    deliver_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_edge_c) begin
          state_d = S_START;
          tcnt_d  = '0;
        end
      end

      S_START: begin
        if (tick_c) begin
          if (tcnt_q == TCNT_MID) begin
            if (!rxs_q) begin
              tcnt_d  = '0;
              bcnt_d  = '0;
              state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end

      S_DATA: begin
        if (tick_c) begin
          // 4-bit wrap returns tcnt to 0 after the mid-bit sample
          tcnt_d = tcnt_q + TCNT_W'(1);
          if (tcnt_q == TCNT_LAST) begin
            sh_d   = {rxs_q, sh_q[DATA_W-1:1]};
            bcnt_d = bcnt_q + BCNT_W'(1);
            if (bcnt_q == BCNT_LAST) begin
              state_d = S_STOP;
            end
          end
        end
      end

      S_STOP: begin
        if (tick_c) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
          if (tcnt_q == TCNT_LAST) begin
            if (rxs_q) begin
              deliver_c = 1'b1;
              state_d   = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_WAIT_HI;
            end
          end
        end
      end

      S_WAIT_HI: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Load into the output register if it is empty or being drained now
    if (deliver_c) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = sh_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      os_d_q        <= 1'b0;
      rx_meta_q     <= 1'b1;
      rxs_q         <= 1'b1;
      rxs_d_q       <= 1'b1;
      fill_q        <= '0;
      armed_q       <= 1'b0;
      tcnt_q        <= '0;
      bcnt_q        <= '0;
      sh_q          <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      os_d_q        <= os_d_d;
      rx_meta_q     <= rx_meta_d;
      rxs_q         <= rxs_d;
      rxs_d_q       <= rxs_d_d;
      fill_q        <= fill_d;
      armed_q       <= armed_d;
      tcnt_q        <= tcnt_d;
      bcnt_q        <= bcnt_d;
      sh_q          <= sh_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      busy_q        <= busy_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uartcon_rx.sv
// Testbench for uartcon_rx: scoreboard of expected bytes popped on transfers.
module tb_uartcon_rx;

  localparam int BIT_CLK = 128;  // os_clk period 8 clk, 16 ticks per bit

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       os_clk = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int xfer_cnt = 0;
  int valid_cyc = 0;
  int fe_cnt = 0;
  int oe_cnt = 0;
  int stab_err = 0;
  int wide_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_fe = 1'b0;
  logic       prev_oe = 1'b0;

  int os_div = 0;

  uartcon_rx #(.OS_MID(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .os_clk      (os_clk),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // 16x oversample clock: toggles every 4 clk as a register output
  always @(posedge clk) begin
    if (os_div == 3) begin
      os_div <= 0;
      os_clk <= ~os_clk;
    end else begin
      os_div <= os_div + 1;
    end
  end

  // Monitor: scoreboard pops on transfers, tallies pulses and stability
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_fe    = 1'b0;
      prev_oe    = 1'b0;
    end else begin
      if (rx_valid) valid_cyc++;
      if (frame_err) fe_cnt++;
      if (overrun_err) oe_cnt++;
      if ((frame_err && prev_fe) || (overrun_err && prev_oe)) wide_err++;
      if (prev_valid && !prev_ready && (!rx_valid || rx_data !== prev_data)) stab_err++;
      if (rx_valid && rx_ready) begin
        xfer_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected: got 0x%02h, required no transfer", rx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (rx_data !== exp_b) begin
            errors++;
            $display("FAIL scoreboard_data: got 0x%02h, required 0x%02h", rx_data, exp_b);
          end
        end
      end
      prev_valid = rx_valid;
      prev_ready = rx_ready;
      prev_data  = rx_data;
      prev_fe    = frame_err;
      prev_oe    = overrun_err;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    step(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    rx_ready = 1'b0;
    step(5);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got 0x%02h, required 0x00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b, required 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_overrun_err: got %b, required 0", overrun_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst = 1'b0;
    step(20);
  endtask

  task automatic test_single();
    int v0, x0, f0, o0;
    v0 = valid_cyc; x0 = xfer_cnt; f0 = fe_cnt; o0 = oe_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(8'h55);
    send_bit(1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid: got %b, required 1", busy); end
    for (int i = 0; i < 8; i++) send_bit(1'(8'h55 >> i));
    send_bit(1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b, required 0", busy); end
    step(64);
    checks++; if (valid_cyc - v0 !== 1) begin errors++; $display("FAIL single_valid_cycles: got %0d, required 1", valid_cyc - v0); end
    checks++; if (xfer_cnt - x0 !== 1) begin errors++; $display("FAIL single_transfers: got %0d, required 1", xfer_cnt - x0); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL single_frame_err: got %0d, required 0", fe_cnt - f0); end
    checks++; if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL single_overrun_err: got %0d, required 0", oe_cnt - o0); end
  endtask

  task automatic test_back_to_back();
    int x0, f0, o0;
    x0 = xfer_cnt; f0 = fe_cnt; o0 = oe_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    step(64);
    checks++; if (xfer_cnt - x0 !== 2) begin errors++; $display("FAIL b2b_transfers: got %0d, required 2", xfer_cnt - x0); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_pending: got %0d, required 0", exp_q.size()); end
    checks++; if ((fe_cnt - f0) + (oe_cnt - o0) !== 0) begin errors++; $display("FAIL b2b_errors: got %0d, required 0", (fe_cnt - f0) + (oe_cnt - o0)); end
  endtask

  task automatic test_glitch();
    int v0, f0, o0;
    v0 = valid_cyc; f0 = fe_cnt; o0 = oe_cnt;
    rxd = 1'b0;
    step(32);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b, required 1", busy); end
    rxd = 1'b1;
    step(200);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_idle: got %b, required 0", busy); end
    checks++; if (valid_cyc - v0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d, required 0", valid_cyc - v0); end
    checks++; if ((fe_cnt - f0) + (oe_cnt - o0) !== 0) begin errors++; $display("FAIL glitch_errors: got %0d, required 0", (fe_cnt - f0) + (oe_cnt - o0)); end
  endtask

  task automatic test_frame_err();
    int v0, x0, f0, o0;
    v0 = valid_cyc; x0 = xfer_cnt; f0 = fe_cnt; o0 = oe_cnt;
    rx_ready = 1'b1;
    send_frame(8'h81, 1'b0);
    step(160);
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d, required 1", fe_cnt - f0); end
    checks++; if (valid_cyc - v0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d, required 0", valid_cyc - v0); end
    checks++; if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL ferr_overrun: got %0d, required 0", oe_cnt - o0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_wait_hi_busy: got %b, required 1", busy); end
    rxd = 1'b1;
    step(64);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_idle_busy: got %b, required 0", busy); end
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    step(64);
    checks++; if (xfer_cnt - x0 !== 1) begin errors++; $display("FAIL ferr_recover_transfers: got %0d, required 1", xfer_cnt - x0); end
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_recover_pulses: got %0d, required 1", fe_cnt - f0); end
  endtask

  task automatic test_overrun();
    int x0, f0, o0, s0;
    x0 = xfer_cnt; f0 = fe_cnt; o0 = oe_cnt; s0 = stab_err;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid: got %b, required 1", rx_valid); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_first_data: got 0x%02h, required 0x11", rx_data); end
    send_frame(8'h22, 1'b1);
    step(64);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_held_valid: got %b, required 1", rx_valid); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_held_data: got 0x%02h, required 0x11", rx_data); end
    checks++; if (oe_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d, required 1", oe_cnt - o0); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL ovr_frame_err: got %0d, required 0", fe_cnt - f0); end
    checks++; if (stab_err - s0 !== 0) begin errors++; $display("FAIL ovr_stability: got %0d violations, required 0", stab_err - s0); end
    rx_ready = 1'b1;
    step(4);
    checks++; if (xfer_cnt - x0 !== 1) begin errors++; $display("FAIL ovr_drain_transfers: got %0d, required 1", xfer_cnt - x0); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_valid: got %b, required 0", rx_valid); end
  endtask

  task automatic test_reset_mid();
    int v0, x0, f0, o0;
    rx_ready = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rxd = 1'b0;
    step(64);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b, required 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got 0x%02h, required 0x00", rx_data); end
    step(4);
    rst = 1'b0;
    v0 = valid_cyc; x0 = xfer_cnt; f0 = fe_cnt; o0 = oe_cnt;
    step(59);
    for (int i = 4; i < 8; i++) send_bit(1'b1);
    send_bit(1'b1);
    step(64);
    checks++; if (valid_cyc - v0 !== 0) begin errors++; $display("FAIL rstmid_partial_valid: got %0d, required 0", valid_cyc - v0); end
    checks++; if ((fe_cnt - f0) + (oe_cnt - o0) !== 0) begin errors++; $display("FAIL rstmid_partial_errors: got %0d, required 0", (fe_cnt - f0) + (oe_cnt - o0)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle_busy: got %b, required 0", busy); end
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    step(64);
    checks++; if (xfer_cnt - x0 !== 1) begin errors++; $display("FAIL rstmid_next_transfers: got %0d, required 1", xfer_cnt - x0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL final_pending: got %0d, required 0", exp_q.size()); end
    checks++; if (wide_err !== 0) begin errors++; $display("FAIL final_pulse_width: got %0d wide pulses, required 0", wide_err); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL final_stability: got %0d violations, required 0", stab_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
